// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the MIPS-subset datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
   logic [5:0] opcode_i;
   logic [5:0] funct_i;
   logic       mem_ready_i;
   logic       pc_write_o;
   logic       pc_write_cond_o;
   logic [1:0] pc_source_o;
   logic       i_or_d_o;
   logic       mem_read_o;
   logic       mem_write_o;
   logic       ir_write_o;
   logic       mem_to_reg_o;
   logic       reg_write_o;
   logic       reg_dst_o;
   logic       alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [1:0] alu_op_o;
   logic       ext_zero_o;
   logic       err_o;
   logic [3:0] state_o;

   modport master (
      input  opcode_i, funct_i, mem_ready_i,
      output pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o,
             mem_write_o, ir_write_o, mem_to_reg_o, reg_write_o, reg_dst_o,
             alu_src_a_o, alu_src_b_o, alu_op_o, ext_zero_o, err_o, state_o
   );

   modport slave (
      output opcode_i, funct_i, mem_ready_i,
      input  pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o,
             mem_write_o, ir_write_o, mem_to_reg_o, reg_write_o, reg_dst_o,
             alu_src_a_o, alu_src_b_o, alu_op_o, ext_zero_o, err_o, state_o
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU.
// Sequences ALU, unified memory port, register file, PC and immediate extender
// over FETCH/DECODE/EXEC/MEM/WB; memory states wait on mem_ready_i with a timeout.
// Optional: define MULTICYCLE_CTRL_JAL_EN to support jal (opcode 000011).
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 8
) (
   input logic               clk_i,
   input logic               rst_i,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      EXEC_I   = 4'd10,
      I_WB     = 4'd11,
      JAL_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef MULTICYCLE_CTRL_JAL_EN
   localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             err, err_n;
   logic             mem_wait;
   logic             timeout;
   logic             unused_funct;

   // funct is decoded by the ALU control unit, not here
   assign unused_funct = ^bus.funct_i;

   assign bus.state_o = state;
   assign bus.err_o   = err;

   // Memory-wait bookkeeping: limit reached with no ready aborts the access
   assign mem_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign timeout  = mem_wait && !bus.mem_ready_i && (cnt == CNT_W'(MEM_TIMEOUT));

   // State, wait counter and error pulse registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= FETCH;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         err   <= err_n;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_n             = state;
      cnt_n               = cnt;
      err_n               = 1'b0;
      bus.pc_write_o      = 1'b0;
      bus.pc_write_cond_o = 1'b0;
      bus.pc_source_o     = 2'd0;
      bus.i_or_d_o        = 1'b0;
      bus.mem_read_o      = 1'b0;
      bus.mem_write_o     = 1'b0;
      bus.ir_write_o      = 1'b0;
      bus.mem_to_reg_o    = 1'b0;
      bus.reg_write_o     = 1'b0;
      bus.reg_dst_o       = 1'b0;
      bus.alu_src_a_o     = 1'b0;
      bus.alu_src_b_o     = 2'd0;
      bus.alu_op_o        = 2'd0;
      bus.ext_zero_o      = (bus.opcode_i == OP_ORI);

      case (state)
         FETCH: begin
            bus.mem_read_o  = 1'b1;
            bus.alu_src_b_o = 2'd1;
            if (bus.mem_ready_i) begin
               bus.ir_write_o = 1'b1;
               bus.pc_write_o = 1'b1;
               state_n        = DECODE;
            end else if (timeout) begin
               err_n = 1'b1;
            end
         end
         DECODE: begin
            bus.alu_src_b_o = 2'd3;
            case (bus.opcode_i)
               OP_RTYPE:               state_n = EXEC_R;
               OP_LW, OP_SW:           state_n = MEM_ADDR;
               OP_BEQ:                 state_n = BRANCH;
               OP_J:                   state_n = JUMP;
               OP_ADDI, OP_SLTI, OP_ORI: state_n = EXEC_I;
`ifdef MULTICYCLE_CTRL_JAL_EN
               OP_JAL:                 state_n = JAL_WB;
`endif
               default: begin
                  state_n = FETCH;
                  err_n   = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            bus.alu_src_a_o = 1'b1;
            bus.alu_src_b_o = 2'd2;
            state_n         = (bus.opcode_i == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            bus.mem_read_o = 1'b1;
            bus.i_or_d_o   = 1'b1;
            if (bus.mem_ready_i) begin
               state_n = MEM_WB;
            end else if (timeout) begin
               state_n = FETCH;
               err_n   = 1'b1;
            end
         end
         MEM_WB: begin
            bus.reg_write_o  = 1'b1;
            bus.mem_to_reg_o = 1'b1;
            state_n          = FETCH;
         end
         MEM_WR: begin
            bus.mem_write_o = 1'b1;
            bus.i_or_d_o    = 1'b1;
            if (bus.mem_ready_i) begin
               state_n = FETCH;
            end else if (timeout) begin
               state_n = FETCH;
               err_n   = 1'b1;
            end
         end
         EXEC_R: begin
            bus.alu_src_a_o = 1'b1;
            bus.alu_op_o    = 2'd2;
            state_n         = R_WB;
         end
         R_WB: begin
            bus.reg_write_o = 1'b1;
            bus.reg_dst_o   = 1'b1;
            state_n         = FETCH;
         end
         EXEC_I: begin
            bus.alu_src_a_o = 1'b1;
            bus.alu_src_b_o = 2'd2;
            case (bus.opcode_i)
               OP_SLTI: bus.alu_op_o = 2'd3;
               OP_ORI:  bus.alu_op_o = 2'd2;
               default: bus.alu_op_o = 2'd0;
            endcase
            state_n = I_WB;
         end
         I_WB: begin
            bus.reg_write_o = 1'b1;
            state_n         = FETCH;
         end
         BRANCH: begin
            bus.alu_src_a_o     = 1'b1;
            bus.alu_op_o        = 2'd1;
            bus.pc_write_cond_o = 1'b1;
            bus.pc_source_o     = 2'd1;
            state_n             = FETCH;
         end
         JUMP: begin
            bus.pc_write_o  = 1'b1;
            bus.pc_source_o = 2'd2;
            state_n         = FETCH;
         end
`ifdef MULTICYCLE_CTRL_JAL_EN
         JAL_WB: begin
            bus.pc_write_o  = 1'b1;
            bus.pc_source_o = 2'd2;
            bus.reg_write_o = 1'b1;
            bus.reg_dst_o   = 1'b1;
            state_n         = FETCH;
         end
`endif
         default: state_n = FETCH;
      endcase

      // Counter restarts on any state change or abort, counts idle memory cycles
      if ((state_n != state) || timeout) begin
         cnt_n = '0;
      end else if (mem_wait && !bus.mem_ready_i) begin
         cnt_n = cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=15).
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.mem_ready_i = 1'b0;
      bus.opcode_i    = OP_LW;
      bus.funct_i     = 6'd0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if (bus.state_o !== 4'd0) begin n_err++; $display("FAIL reset_state_in_reset: got %0d want 0", bus.state_o); end
      rst_n = 1'b1;
      #1;
      n_vec++; if (bus.state_o !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
      n_vec++; if (bus.mem_read_o !== 1'b1) begin n_err++; $display("FAIL reset_mem_read: got %b want 1", bus.mem_read_o); end
      n_vec++; if ({bus.pc_write_o, bus.pc_write_cond_o, bus.ir_write_o, bus.reg_write_o, bus.mem_write_o} !== 5'b0)
         begin n_err++; $display("FAIL reset_write_enables: got %b want 00000", {bus.pc_write_o, bus.pc_write_cond_o, bus.ir_write_o, bus.reg_write_o, bus.mem_write_o}); end
      n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
      n_vec++; if (bus.alu_src_b_o !== 2'd1) begin n_err++; $display("FAIL reset_alu_src_b: got %0d want 1", bus.alu_src_b_o); end
   endtask

   task automatic test_lw();
      int st[6] = '{0, 1, 2, 3, 4, 0};
      bus.opcode_i    = OP_LW;
      bus.mem_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_vec++; if (bus.state_o !== 4'(st[i])) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
         n_vec++; if (bus.reg_write_o !== (st[i] == 4)) begin n_err++; $display("FAIL lw_reg_write[%0d]: got %b want %b", i, bus.reg_write_o, st[i] == 4); end
         n_vec++; if (bus.mem_to_reg_o !== (st[i] == 4)) begin n_err++; $display("FAIL lw_mem_to_reg[%0d]: got %b want %b", i, bus.mem_to_reg_o, st[i] == 4); end
         n_vec++; if (bus.ir_write_o !== (st[i] == 0)) begin n_err++; $display("FAIL lw_ir_write[%0d]: got %b want %b", i, bus.ir_write_o, st[i] == 0); end
         n_vec++; if (bus.i_or_d_o !== (st[i] == 3)) begin n_err++; $display("FAIL lw_i_or_d[%0d]: got %b want %b", i, bus.i_or_d_o, st[i] == 3); end
         if (i < 5) tick();
      end
   endtask

   task automatic test_sw();
      int st[5] = '{0, 1, 2, 5, 0};
      bus.opcode_i    = OP_SW;
      bus.mem_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++; if (bus.state_o !== 4'(st[i])) begin n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
         n_vec++; if (bus.mem_write_o !== (st[i] == 5)) begin n_err++; $display("FAIL sw_mem_write[%0d]: got %b want %b", i, bus.mem_write_o, st[i] == 5); end
         n_vec++; if (bus.reg_write_o !== 1'b0) begin n_err++; $display("FAIL sw_reg_write[%0d]: got %b want 0", i, bus.reg_write_o); end
         if (i < 4) tick();
      end
   endtask

   task automatic test_rtype();
      int st[5] = '{0, 1, 6, 7, 0};
      bus.opcode_i    = OP_RTYPE;
      bus.funct_i     = 6'b100000;
      bus.mem_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++; if (bus.state_o !== 4'(st[i])) begin n_err++; $display("FAIL r_state[%0d]: got %0d want %0d", i, bus.state_o, st[i]); end
         if (st[i] == 6) begin
            n_vec++; if (bus.alu_op_o !== 2'd2 || bus.alu_src_a_o !== 1'b1) begin n_err++; $display("FAIL r_exec: got op=%0d a=%b want op=2 a=1", bus.alu_op_o, bus.alu_src_a_o); end
         end
         n_vec++; if ({bus.reg_write_o, bus.reg_dst_o} !== ((st[i] == 7) ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL r_wb[%0d]: got %b%b", i, bus.reg_write_o, bus.reg_dst_o); end
         if (i < 4) tick();
      end
   endtask

   task automatic test_branch_jump();
      int st_b[4] = '{0, 1, 8, 0};
      int st_j[4] = '{0, 1, 9, 0};
      bus.opcode_i    = OP_BEQ;
      bus.mem_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++; if (bus.state_o !== 4'(st_b[i])) begin n_err++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, bus.state_o, st_b[i]); end
         if (st_b[i] == 8) begin
            n_vec++; if ({bus.pc_write_cond_o, bus.alu_op_o, bus.pc_source_o, bus.pc_write_o} !== 6'b1_01_01_0)
               begin n_err++; $display("FAIL beq_ctrl: got %b want 101010", {bus.pc_write_cond_o, bus.alu_op_o, bus.pc_source_o, bus.pc_write_o}); end
         end
         if (i < 3) tick();
      end
      bus.opcode_i = OP_J;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++; if (bus.state_o !== 4'(st_j[i])) begin n_err++; $display("FAIL j_state[%0d]: got %0d want %0d", i, bus.state_o, st_j[i]); end
         if (st_j[i] == 9) begin
            n_vec++; if ({bus.pc_write_o, bus.pc_source_o, bus.reg_write_o} !== 4'b1_10_0)
               begin n_err++; $display("FAIL j_ctrl: got %b want 1100", {bus.pc_write_o, bus.pc_source_o, bus.reg_write_o}); end
         end
         if (i < 3) tick();
      end
   endtask

   task automatic test_imm();
      logic [5:0] ops[3]  = '{OP_ORI, OP_ADDI, OP_SLTI};
      logic       ez[3]   = '{1'b1, 1'b0, 1'b0};
      logic [1:0] aop[3]  = '{2'd2, 2'd0, 2'd3};
      int         st[5]   = '{0, 1, 10, 11, 0};
      bus.mem_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.opcode_i = ops[k];
         for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (bus.state_o !== 4'(st[i])) begin n_err++; $display("FAIL imm%0d_state[%0d]: got %0d want %0d", k, i, bus.state_o, st[i]); end
            n_vec++; if (bus.ext_zero_o !== ez[k]) begin n_err++; $display("FAIL imm%0d_ext_zero[%0d]: got %b want %b", k, i, bus.ext_zero_o, ez[k]); end
            if (st[i] == 10) begin
               n_vec++; if ({bus.alu_op_o, bus.alu_src_b_o, bus.alu_src_a_o} !== {aop[k], 2'd2, 1'b1})
                  begin n_err++; $display("FAIL imm%0d_exec: got %b want %b", k, {bus.alu_op_o, bus.alu_src_b_o, bus.alu_src_a_o}, {aop[k], 2'd2, 1'b1}); end
            end
            n_vec++; if ({bus.reg_write_o, bus.reg_dst_o} !== ((st[i] == 11) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL imm%0d_wb[%0d]: got %b%b", k, i, bus.reg_write_o, bus.reg_dst_o); end
            if (i < 4) tick();
         end
      end
   endtask

   task automatic test_timeout();
      bus.opcode_i    = OP_LW;
      bus.mem_ready_i = 1'b1;
      tick();
      tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd2) begin n_err++; $display("FAIL to_pre_state: got %0d want 2", bus.state_o); end
      bus.mem_ready_i = 1'b0;
      tick();
      // counter 0..14 waits, then the limit cycle with ready still low aborts
      for (int k = 0; k < 16; k++) begin
         #1;
         n_vec++; if (bus.state_o !== 4'd3 || bus.err_o !== 1'b0 || bus.reg_write_o !== 1'b0)
            begin n_err++; $display("FAIL to_wait[%0d]: got state=%0d err=%b rw=%b want 3/0/0", k, bus.state_o, bus.err_o, bus.reg_write_o); end
         tick();
      end
      #1;
      n_vec++; if (bus.state_o !== 4'd0) begin n_err++; $display("FAIL to_abort_state: got %0d want 0", bus.state_o); end
      n_vec++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL to_err_pulse: got %b want 1", bus.err_o); end
      n_vec++; if ({bus.reg_write_o, bus.ir_write_o, bus.pc_write_o} !== 3'b000) begin n_err++; $display("FAIL to_no_write: got %b want 000", {bus.reg_write_o, bus.ir_write_o, bus.pc_write_o}); end
      tick();
      #1;
      n_vec++; if (bus.err_o !== 1'b0 || bus.state_o !== 4'd0) begin n_err++; $display("FAIL to_err_single: got err=%b state=%0d want 0/0", bus.err_o, bus.state_o); end

      // ready arriving on the limit cycle completes the store
      bus.opcode_i    = OP_SW;
      bus.mem_ready_i = 1'b1;
      tick();
      tick();
      bus.mem_ready_i = 1'b0;
      tick();
      for (int k = 0; k < 15; k++) tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd5 || bus.mem_write_o !== 1'b1) begin n_err++; $display("FAIL lim_state: got state=%0d mw=%b want 5/1", bus.state_o, bus.mem_write_o); end
      bus.mem_ready_i = 1'b1;
      tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd0 || bus.err_o !== 1'b0) begin n_err++; $display("FAIL lim_success: got state=%0d err=%b want 0/0", bus.state_o, bus.err_o); end
   endtask

   task automatic test_illegal();
      bus.opcode_i    = 6'b111111;
      bus.mem_ready_i = 1'b1;
      tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd1 || bus.err_o !== 1'b0) begin n_err++; $display("FAIL ill_decode: got state=%0d err=%b want 1/0", bus.state_o, bus.err_o); end
      tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd0 || bus.err_o !== 1'b1) begin n_err++; $display("FAIL ill_err: got state=%0d err=%b want 0/1", bus.state_o, bus.err_o); end
      bus.mem_ready_i = 1'b0;
      tick();
      #1;
      n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL ill_err_single: got %b want 0", bus.err_o); end
   endtask

   task automatic test_jal();
      bus.opcode_i    = OP_JAL;
      bus.mem_ready_i = 1'b1;
      tick();
      tick();
      #1;
`ifdef MULTICYCLE_CTRL_JAL_EN
      n_vec++; if (bus.state_o !== 4'd12) begin n_err++; $display("FAIL jal_state: got %0d want 12", bus.state_o); end
      n_vec++; if ({bus.pc_write_o, bus.pc_source_o, bus.reg_write_o, bus.reg_dst_o} !== 5'b1_10_1_1)
         begin n_err++; $display("FAIL jal_ctrl: got %b want 11011", {bus.pc_write_o, bus.pc_source_o, bus.reg_write_o, bus.reg_dst_o}); end
      tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd0 || bus.err_o !== 1'b0) begin n_err++; $display("FAIL jal_done: got state=%0d err=%b want 0/0", bus.state_o, bus.err_o); end
`else
      n_vec++; if (bus.state_o !== 4'd0 || bus.err_o !== 1'b1) begin n_err++; $display("FAIL jal_illegal: got state=%0d err=%b want 0/1", bus.state_o, bus.err_o); end
      n_vec++; if (bus.reg_write_o !== 1'b0) begin n_err++; $display("FAIL jal_no_write: got %b want 0", bus.reg_write_o); end
`endif
      bus.mem_ready_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.opcode_i    = OP_SW;
      bus.mem_ready_i = 1'b1;
      tick();
      tick();
      bus.mem_ready_i = 1'b0;
      tick();
      #1;
      n_vec++; if (bus.state_o !== 4'd5 || bus.mem_write_o !== 1'b1) begin n_err++; $display("FAIL rm_pre: got state=%0d mw=%b want 5/1", bus.state_o, bus.mem_write_o); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.state_o !== 4'd0 || bus.mem_write_o !== 1'b0) begin n_err++; $display("FAIL rm_abort: got state=%0d mw=%b want 0/0", bus.state_o, bus.mem_write_o); end
      bus.mem_ready_i = 1'b1;
      tick();
      rst_n = 1'b1;
      #1;
      n_vec++; if (bus.state_o !== 4'd0 || bus.err_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin n_err++; $display("FAIL rm_release: got state=%0d err=%b mw=%b want 0/0/0", bus.state_o, bus.err_o, bus.mem_write_o); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_lw();
      test_sw();
      test_rtype();
      test_branch_jump();
      test_imm();
      test_timeout();
      test_illegal();
      test_jal();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
